// File: rtl/alarm_pkg.sv
// Purpose : shared types and time-field constants for the alarm ringer slice.
// Latency : n/a (package only).
// Backpressure: n/a.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    localparam int TIME_W   = 6;
    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    // Alarm fires only on the first second of the armed minute, so it can
    // trigger at most once per alarm minute.
    function automatic logic is_alarm_time(
        input logic [TIME_W-1:0] hour,
        input logic [TIME_W-1:0] minute,
        input logic [TIME_W-1:0] second,
        input logic [TIME_W-1:0] a_hour,
        input logic [TIME_W-1:0] a_min
    );
        return (hour == a_hour) && (minute == a_min) && (second == '0);
    endfunction

endpackage

// File: rtl/alarm_sec_counter.sv
// Purpose : loadable seconds down-counter for snooze; done pulses on the 1->0 tick.
// Latency : count updates on the clk edge after load/tick; done is combinational on that tick.
// Backpressure: none; ticks are always consumed, counter holds at 0.
// Ports   : clk, rst (async active-low), tick (1 Hz strobe), clr, load, load_val, done.
module alarm_sec_counter #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = tick && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_match_ringer.sv
// Purpose : compares running time to the alarm time and drives ring/snooze/missed/buzzer.
// Latency : 1 clk from match tick or button pulse to registered outputs.
// Backpressure: none; buttons and ticks are single-cycle pulses acted on immediately.
// Ports   : clk, rst (async active-low), tick_1hz, cur_hour/min/sec, alarm_hour/min,
//           alarm_en, stop_btn, snooze_btn -> buzzer, ringing, snoozed, missed.
// Option  : ALARM_BEEP_PATTERN_EN - buzzer toggles each second while ringing
//           (default: buzzer follows ringing as a solid tone).
module alarm_match_ringer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SECS  = 60
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_min,
    input  logic [TIME_W-1:0] cur_sec,
    input  logic [TIME_W-1:0] alarm_hour,
    input  logic [TIME_W-1:0] alarm_min,
    input  logic              alarm_en,
    input  logic              stop_btn,
    input  logic              snooze_btn,
    output logic              buzzer,
    output logic              ringing,
    output logic              snoozed,
    output logic              missed
);

    localparam int               SNOOZE_SECS = SNOOZE_MIN * 60;
    localparam int               SNZ_W       = $clog2(SNOOZE_SECS + 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD    = SNZ_W'(SNOOZE_SECS);
    localparam logic [7:0]       RING_LAST   = 8'(RING_SECS - 1);

    state_e     state_q, state_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       missed_q, missed_d;
    logic       ringing_q, snoozed_q;
    logic       match;
    logic       snz_load, snz_clr, snz_done;

    assign match = tick_1hz && alarm_en &&
                   is_alarm_time(cur_hour, cur_min, cur_sec, alarm_hour, alarm_min);

    // Kept outside the FSM block so the counter's done output never feeds back
    // into its own control inputs.
    assign snz_load = alarm_en && (state_q == RING) && snooze_btn && !stop_btn;
    assign snz_clr  = !alarm_en || ((state_q == SNOOZE) && stop_btn);

    alarm_sec_counter #(
        .W (SNZ_W)
    ) u_snz_cnt (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick_1hz),
        .clr      (snz_clr),
        .load     (snz_load),
        .load_val (SNZ_LOAD),
        .done     (snz_done)
    );

    // Priority: disarm > stop > snooze > tick-driven timeout/expiry.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        missed_d   = missed_q;
        if (!alarm_en) begin
            state_d    = IDLE;
            ring_cnt_d = '0;
            missed_d   = 1'b0;
        end else begin
            // stop clears a pending missed flag in any state
            if (stop_btn) begin
                missed_d = 1'b0;
            end
            case (state_q)
                IDLE: begin
                    // a match beats a simultaneous stop: stop has nothing to act on here
                    if (match) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state_d    = IDLE;
                        ring_cnt_d = '0;
                    end else if (snooze_btn) begin
                        state_d    = SNOOZE;
                        ring_cnt_d = '0;
                    end else if (tick_1hz) begin
                        if (ring_cnt_q == RING_LAST) begin
                            state_d    = IDLE;
                            ring_cnt_d = '0;
                            missed_d   = 1'b1;
                        end else begin
                            ring_cnt_d = ring_cnt_q + 8'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (snz_done) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    ring_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            missed_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            missed_q   <= missed_d;
            ringing_q  <= (state_d == RING);
            snoozed_q  <= (state_d == SNOOZE);
        end
    end

    assign ringing = ringing_q;
    assign snoozed = snoozed_q;
    assign missed  = missed_q;

`ifdef ALARM_BEEP_PATTERN_EN
    logic buzz_q, buzz_d;

    // On entry to RING the buzzer starts high, then flips on every tick.
    always_comb begin
        buzz_d = 1'b0;
        if (state_d == RING) begin
            if (state_q != RING) begin
                buzz_d = 1'b1;
            end else if (tick_1hz) begin
                buzz_d = !buzz_q;
            end else begin
                buzz_d = buzz_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buzz_q <= 1'b0;
        end else begin
            buzz_q <= buzz_d;
        end
    end

    assign buzzer = buzz_q;
`else
    assign buzzer = ringing_q;
`endif

endmodule

// File: tb/tb_alarm_match_ringer.sv
// Purpose : directed self-checking bench for alarm_match_ringer (alarm 07:30).
// Latency : outputs sampled 1 ns after each rising edge.
// Backpressure: n/a.
module tb_alarm_match_ringer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [5:0] cur_hour, cur_min, cur_sec;
    logic [5:0] alarm_hour, alarm_min;
    logic       alarm_en, stop_btn, snooze_btn;
    logic       buzzer, ringing, snoozed, missed;

    int n_checks = 0;
    int n_errs   = 0;
    logic any_ring;

`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif

    alarm_match_ringer #(
        .SNOOZE_MIN (5),
        .RING_SECS  (60)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_en   (alarm_en),
        .stop_btn   (stop_btn),
        .snooze_btn (snooze_btn),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozed    (snoozed),
        .missed     (missed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick cycle (with optional buttons on the same edge) then one quiet cycle.
    task automatic tick_at(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                           input logic stp = 1'b0, input logic snz = 1'b0);
        cur_hour   = h;
        cur_min    = m;
        cur_sec    = s;
        tick_1hz   = 1'b1;
        stop_btn   = stp;
        snooze_btn = snz;
        step();
        tick_1hz   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_at(6'd7, 6'd31, 6'd1);
    endtask

    task automatic pulse(input logic stp, input logic snz);
        stop_btn   = stp;
        snooze_btn = snz;
        step();
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        tick_1hz   = 1'b0;
        cur_hour   = '0;
        cur_min    = '0;
        cur_sec    = '0;
        alarm_hour = 6'd7;
        alarm_min  = 6'd30;
        alarm_en   = 1'b0;
        stop_btn   = 1'b0;
        snooze_btn = 1'b0;
        repeat (2) step();
        chk("rst_ringing", ringing, 0);
        chk("rst_buzzer",  buzzer,  0);
        chk("rst_snoozed", snoozed, 0);
        chk("rst_missed",  missed,  0);
        rst = 1'b1;
        step();
        alarm_en = 1'b1;
        step();

        // near misses
        tick_at(6'd7, 6'd29, 6'd59);
        chk("no_match_prev_min", ringing, 0);
        tick_at(6'd7, 6'd31, 6'd0);
        chk("no_match_next_min", ringing, 0);

        // match: one clk latency
        cur_hour = 6'd7; cur_min = 6'd30; cur_sec = 6'd0;
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        chk("match_ringing", ringing, 1);
        chk("match_buzzer",  buzzer,  1);
        chk("match_snoozed", snoozed, 0);
        step();

        pulse(1'b1, 1'b0);
        chk("stop_ringing", ringing, 0);
        chk("stop_buzzer",  buzzer,  0);
        chk("stop_missed",  missed,  0);
        any_ring = 1'b0;
        for (int s = 1; s < 60; s++) begin
            tick_at(6'd7, 6'd30, 6'(s));
            any_ring |= ringing;
        end
        chk("no_retrigger", any_ring, 0);

        // buzzer pattern, then snooze for 300 ticks
        tick_at(6'd7, 6'd30, 6'd0);
        chk("ring2", ringing, 1);
        for (int k = 1; k <= 3; k++) begin
            tick_at(6'd7, 6'd30, 6'(k));
            chk("beep_pattern", buzzer, BEEP ? 32'((k % 2) == 0) : 32'd1);
        end
        pulse(1'b0, 1'b1);
        chk("snz_snoozed", snoozed, 1);
        chk("snz_ringing", ringing, 0);
        chk("snz_buzzer",  buzzer,  0);
        ticks(299);
        chk("snz_299_snoozed", snoozed, 1);
        chk("snz_299_ringing", ringing, 0);
        ticks(1);
        chk("snz_300_ringing", ringing, 1);
        chk("snz_300_snoozed", snoozed, 0);
        chk("snz_300_buzzer",  buzzer,  1);

        // auto-off after 60 unattended ticks
        ticks(59);
        chk("timeout_59_ringing", ringing, 1);
        ticks(1);
        chk("timeout_ringing", ringing, 0);
        chk("timeout_buzzer",  buzzer,  0);
        chk("timeout_missed",  missed,  1);
        repeat (5) step();
        chk("missed_sticky", missed, 1);
        pulse(1'b1, 1'b0);
        chk("stop_clears_missed", missed, 0);

        // snooze then stop on tick 150
        tick_at(6'd7, 6'd30, 6'd0);
        pulse(1'b0, 1'b1);
        ticks(149);
        chk("snz_149", snoozed, 1);
        tick_at(6'd7, 6'd31, 6'd1, 1'b1, 1'b0);
        chk("snz_stop_snoozed", snoozed, 0);
        chk("snz_stop_ringing", ringing, 0);
        any_ring = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick_at(6'd7, 6'd31, 6'd1);
            any_ring |= ringing;
        end
        chk("snz_stop_no_ring", any_ring, 0);

        // stop + snooze together: stop wins
        tick_at(6'd7, 6'd30, 6'd0);
        pulse(1'b1, 1'b1);
        chk("both_ringing", ringing, 0);
        chk("both_snoozed", snoozed, 0);

        // snooze on the timeout tick: button wins
        tick_at(6'd7, 6'd30, 6'd0);
        ticks(59);
        tick_at(6'd7, 6'd31, 6'd1, 1'b0, 1'b1);
        chk("btn_vs_timeout_snoozed", snoozed, 1);
        chk("btn_vs_timeout_missed",  missed,  0);

        // disarm mid-snooze
        ticks(10);
        alarm_en = 1'b0;
        step();
        chk("disarm_snoozed", snoozed, 0);
        chk("disarm_ringing", ringing, 0);
        chk("disarm_buzzer",  buzzer,  0);
        chk("disarm_missed",  missed,  0);
        alarm_en = 1'b1;
        step();

        // disarm clears missed
        tick_at(6'd7, 6'd30, 6'd0);
        ticks(60);
        chk("missed_again", missed, 1);
        alarm_en = 1'b0;
        step();
        chk("disarm_clears_missed", missed, 0);
        alarm_en = 1'b1;
        step();

        // match while ringing does not restart the ring count
        tick_at(6'd7, 6'd30, 6'd0);
        ticks(5);
        tick_at(6'd7, 6'd30, 6'd0);
        ticks(53);
        chk("rematch_59_ringing", ringing, 1);
        ticks(1);
        chk("rematch_timeout", ringing, 0);
        chk("rematch_missed",  missed,  1);
        pulse(1'b1, 1'b0);

        // match with stop in IDLE: match wins
        tick_at(6'd7, 6'd30, 6'd0, 1'b1, 1'b0);
        chk("idle_match_stop", ringing, 1);

        // async reset between edges
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_ringing", ringing, 0);
        chk("arst_buzzer",  buzzer,  0);
        chk("arst_snoozed", snoozed, 0);
        chk("arst_missed",  missed,  0);
        #2 rst = 1'b1;
        step();
        chk("post_arst_ringing", ringing, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
